// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 hash-search scheduler.
package md5_pkg;

    localparam int MD5_BLOCK_W  = 512;
    localparam int MD5_DIGEST_W = 128;
    localparam int MD5_PIPE_LAT = 65;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/md5_inflight.sv
// In-flight tracker: follows each issued block through the fixed md5core
// latency and counts results as they retire in issue order.
module md5_inflight
    import md5_pkg::*;
#(
    parameter int PIPE_LAT = MD5_PIPE_LAT,
    parameter int IDX_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             issue,
    output logic             res_v,
    output logic [IDX_W-1:0] retired
);

    logic [PIPE_LAT-1:0] valid_sr;

    // Valid bits march alongside the core pipeline; reset discards anything in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_sr <= '0;
        end else begin
            valid_sr <= {valid_sr[PIPE_LAT-2:0], issue};
        end
    end

    assign res_v = valid_sr[PIPE_LAT-1];

    // Retired count doubles as the index of the candidate whose digest is on the bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired <= '0;
        end else if (clear) begin
            retired <= '0;
        end else if (res_v) begin
            retired <= retired + IDX_W'(1);
        end
    end

endmodule

// File: rtl/md5_sched.sv
// Issue scheduler and first-match checker wrapped around a pipelined md5core.
module md5_sched
    import md5_pkg::*;
#(
    parameter int PIPE_LAT = MD5_PIPE_LAT,
    parameter int IDX_W    = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [MD5_DIGEST_W-1:0] target_hash,
    input  logic [IDX_W-1:0]        num_cand,
    input  logic                    cand_valid,
    output logic                    cand_ready,
    input  logic [MD5_BLOCK_W-1:0]  cand_mesg,
    output logic                    core_en,
    output logic [MD5_BLOCK_W-1:0]  core_mesg,
    input  logic [31:0]             core_a,
    input  logic [31:0]             core_b,
    input  logic [31:0]             core_c,
    input  logic [31:0]             core_d,
    output logic                    busy,
    output logic                    done,
    output logic                    match,
    output logic [IDX_W-1:0]        match_idx
);

    sched_state_t            state;
    sched_state_t            state_nxt;
    logic [MD5_DIGEST_W-1:0] target_q;
    logic [IDX_W-1:0]        num_q;
    logic [IDX_W-1:0]        issued;
    logic [IDX_W-1:0]        retired;
    logic [IDX_W-1:0]        outstanding;
    logic                    found;
    logic                    res_v;
    logic                    accept;
    logic                    hit;
    logic                    job_start;

    assign job_start   = (state == ST_IDLE) && start;
    assign cand_ready  = (state == ST_RUN) && (issued < num_q) && !found;
    assign accept      = cand_valid && cand_ready;
    assign hit         = res_v && ({core_a, core_b, core_c, core_d} == target_q) && !found;
    assign outstanding = issued - retired;
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);

    md5_inflight #(
        .PIPE_LAT (PIPE_LAT),
        .IDX_W    (IDX_W)
    ) u_inflight (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (job_start),
        .issue   (core_en),
        .res_v   (res_v),
        .retired (retired)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: stop issuing on the last candidate or the first hit, then wait for the pipe to empty.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (num_cand == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (hit || (accept && ((issued + IDX_W'(1)) == num_q))) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((outstanding == '0) && !res_v) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Issue register: an accepted block goes to the core on the following cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_en   <= 1'b0;
            core_mesg <= '0;
            issued    <= '0;
        end else begin
            core_en <= accept;
            if (job_start) begin
                issued <= '0;
            end else if (accept) begin
                core_mesg <= cand_mesg;
                issued    <= issued + IDX_W'(1);
            end
        end
    end

    // Job parameters and first-match capture; later hits in the same job are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target_q  <= '0;
            num_q     <= '0;
            found     <= 1'b0;
            match     <= 1'b0;
            match_idx <= '0;
        end else if (job_start) begin
            target_q  <= target_hash;
            num_q     <= num_cand;
            found     <= 1'b0;
            match     <= 1'b0;
            match_idx <= '0;
        end else if (hit) begin
            found     <= 1'b1;
            match     <= 1'b1;
            match_idx <= retired;
        end
    end

endmodule

// File: tb/tb_md5_sched.sv
// Self-checking bench for md5_sched with a behavioural md5core stand-in.
module tb_md5_sched;
    import md5_pkg::*;

    localparam int L     = MD5_PIPE_LAT;
    localparam int IDX_W = 32;
    localparam logic [127:0] FOX_DIG = 128'h9e107d9d372bb6826bd81d3542a419d6;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start;
    logic [127:0]       target_hash;
    logic [IDX_W-1:0]   num_cand;
    logic               cand_valid;
    logic               cand_ready;
    logic [511:0]       cand_mesg;
    logic               core_en;
    logic [511:0]       core_mesg;
    logic [31:0]        core_a, core_b, core_c, core_d;
    logic               busy, done, match;
    logic [IDX_W-1:0]   match_idx;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int cyc       = 0;
    int en_cnt    = 0;
    int done_cnt  = 0;
    int done_cyc  = 0;

    logic [511:0] cands[$];
    int           due_q[$];
    logic [127:0] dig_q[$];
    logic [511:0] fox_blk, cog_blk;

    int               res_lat, res_en, res_done;
    logic             res_match;
    logic [IDX_W-1:0] res_idx;

    md5_sched #(.PIPE_LAT(L), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .target_hash(target_hash),
        .num_cand(num_cand), .cand_valid(cand_valid), .cand_ready(cand_ready),
        .cand_mesg(cand_mesg), .core_en(core_en), .core_mesg(core_mesg),
        .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d),
        .busy(busy), .done(done), .match(match), .match_idx(match_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event counters sampled mid-cycle.
    always @(negedge clk) begin
        if (core_en === 1'b1) en_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic logic [511:0] pad_msg(input string s);
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < s.len(); i++) b[i*8 +: 8] = s[i];
        b[s.len()*8 +: 8] = 8'h80;
        b[448 +: 64] = 64'(s.len() * 8);
        return b;
    endfunction

    // Stand-in digest: the real fox digest for the fox block, a fold otherwise.
    function automatic logic [127:0] core_digest(input logic [511:0] b);
        if (b == fox_blk) return FOX_DIG;
        return b[127:0] ^ b[255:128] ^ {b[319:256], b[383:320]} ^ {b[447:384], b[511:448]} ^ 128'h5a5a;
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Core model: a block seen with core_en in cycle k shows its digest in cycle k+L.
    initial begin
        forever begin
            @(negedge clk);
            if (core_en === 1'b1) begin
                due_q.push_back(cyc + L);
                dig_q.push_back(core_digest(core_mesg));
            end
        end
    end

    initial begin
        {core_a, core_b, core_c, core_d} = '0;
        forever begin
            @(posedge clk);
            #1;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                {core_a, core_b, core_c, core_d} = dig_q.pop_front();
                void'(due_q.pop_front());
            end else begin
                {core_a, core_b, core_c, core_d} = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_cand_ready"}, cand_ready, 0);
        checkOutput({tag, "_core_en"}, core_en, 0);
        checkOutput({tag, "_core_mesg"}, core_mesg[127:0] | core_mesg[511:384], 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_match"}, match, 0);
        checkOutput({tag, "_match_idx"}, match_idx, 0);
    endtask

    // Runs one job from the cands queue and records what the DUT did.
    task automatic applyStimulus(input int num, input int bubble_pct, input logic [3:0] pattern,
                                 input int offer_limit, input bit glitch, input logic [127:0] tgt);
        int idx, t, en_base, done_base, start_cyc;
        bit hs, offer;
        idx = 0;
        t   = 0;
        @(posedge clk); #1;
        start = 1'b1; target_hash = tgt; num_cand = IDX_W'(num);
        start_cyc = cyc; en_base = en_cnt; done_base = done_cnt;
        @(posedge clk); #1;
        start = 1'b0; target_hash = {$urandom, $urandom, $urandom, $urandom}; num_cand = $urandom;
        while (done_cnt == done_base && t < 1000) begin
            offer = (idx < num) && (idx < offer_limit || match);
            if (pattern != 4'd0) offer = offer && pattern[t % 4];
            else if ($urandom_range(99) < bubble_pct) offer = 1'b0;
            cand_valid = offer;
            if (offer) cand_mesg = cands[idx];
            else cand_mesg = rand_blk();
            if (glitch && t == 2) begin
                start = 1'b1; num_cand = $urandom; target_hash = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (t == 0) checkOutput("busy_rise", busy, 1);
            hs = cand_valid && cand_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            t++;
        end
        cand_valid = 1'b0;
        start      = 1'b0;
        checkOutput("busy_fall", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        res_done  = done_cnt - done_base;
        res_lat   = done_cyc - start_cyc;
        res_en    = en_cnt - en_base;
        res_match = match;
        res_idx   = match_idx;
    endtask

    // Reference: first candidate whose digest equals the target, plus issue and latency rules.
    task automatic verifyJob(input string name, input int num, input logic [127:0] tgt, input bit b2b);
        int m, k;
        m = -1;
        for (int i = 0; i < num; i++) if (m < 0 && core_digest(cands[i]) == tgt) m = i;
        checkOutput({name, "_done"}, res_done, 1);
        checkOutput({name, "_match"}, res_match, (m >= 0));
        checkOutput({name, "_idx"}, res_idx, (m >= 0) ? m : 0);
        if (b2b) begin
            k = (m < 0) ? num : ((m + L + 2 < num) ? m + L + 2 : num);
            checkOutput({name, "_en"}, res_en, k);
            checkOutput({name, "_lat"}, res_lat, (num == 0) ? 1 : k + L + 3);
        end else if (m >= 0) begin
            checkOutput({name, "_en_range"}, (res_en >= m + 1 && res_en <= num), 1);
        end else begin
            checkOutput({name, "_en"}, res_en, num);
        end
    endtask

    initial begin
        int num, mode, h, bubble;
        bit glitch;
        logic [127:0] tgt;

        reset_n = 1'b0; start = 1'b0; cand_valid = 1'b0; cand_mesg = '0;
        target_hash = '0; num_cand = '0;
        fox_blk = pad_msg("The quick brown fox jumps over the lazy dog");
        cog_blk = pad_msg("The quick brown fox jumps over the lazy cog");
        repeat (3) @(posedge clk);
        #1;
        checkReset("por");
        reset_n = 1'b1;

        cands = {fox_blk};
        applyStimulus(1, 0, 4'd0, 1, 1'b0, FOX_DIG);
        verifyJob("single", 1, FOX_DIG, 1'b1);

        cands.delete();
        for (int i = 0; i < 8; i++) cands.push_back(i == 5 ? fox_blk : cog_blk);
        applyStimulus(8, 0, 4'd0, 6, 1'b0, FOX_DIG);
        verifyJob("mid", 8, FOX_DIG, 1'b0);
        checkOutput("mid_en_exact", res_en, 6);

        cands.delete();
        for (int i = 0; i < 4; i++) cands.push_back(rand_blk());
        applyStimulus(4, 0, 4'd0, 4, 1'b0, '0);
        verifyJob("nomatch", 4, '0, 1'b1);

        cands.delete();
        for (int i = 0; i < 4; i++) cands.push_back(i == 1 ? fox_blk : cog_blk);
        applyStimulus(4, 0, 4'b1001, 4, 1'b0, FOX_DIG);
        verifyJob("bubble", 4, FOX_DIG, 1'b0);

        cands.delete();
        applyStimulus(0, 0, 4'd0, 0, 1'b0, FOX_DIG);
        verifyJob("zero", 0, FOX_DIG, 1'b1);

        cands.delete();
        for (int i = 0; i < 6; i++) cands.push_back(rand_blk());
        tgt = core_digest(cands[2]);
        applyStimulus(6, 0, 4'd0, 6, 1'b1, tgt);
        verifyJob("glitch", 6, tgt, 1'b1);

        // Reset in the middle of a job with blocks in flight.
        cands.delete();
        for (int i = 0; i < 20; i++) cands.push_back(i == 3 ? fox_blk : rand_blk());
        @(posedge clk); #1;
        start = 1'b1; target_hash = FOX_DIG; num_cand = 20;
        h = done_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cand_valid = 1'b1; cand_mesg = cands[i];
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        cand_valid = 1'b0;
        #1;
        checkReset("midjob");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (L + 10) @(posedge clk);
        #1;
        checkOutput("rst_no_done", done_cnt - h, 0);
        checkOutput("rst_match", match, 0);
        cands = {fox_blk};
        applyStimulus(1, 0, 4'd0, 1, 1'b0, FOX_DIG);
        verifyJob("after_rst", 1, FOX_DIG, 1'b1);

        // Randomised jobs against the reference.
        for (int j = 0; j < 20; j++) begin
            num = $urandom_range(10);
            cands.delete();
            for (int i = 0; i < num; i++) cands.push_back(rand_blk());
            mode = (num == 0) ? 0 : $urandom_range(2);
            if (mode == 0) begin
                tgt = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                h = $urandom_range(num - 1);
                tgt = core_digest(cands[h]);
                if (mode == 2 && h + 1 < num) cands[num - 1] = cands[h];
            end
            bubble = ($urandom_range(1) == 0) ? 0 : $urandom_range(60, 10);
            glitch = (num > 0) && ($urandom_range(1) == 1);
            applyStimulus(num, bubble, 4'd0, num, glitch, tgt);
            verifyJob($sformatf("rand%0d", j), num, tgt, (bubble == 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
